// File: rtl/uart_buffered_tx_if.sv
// Byte handshake and status bundle for uart_buffered_tx.
interface uart_buffered_tx_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]        DataIn;
  logic              DataInValid;
  logic              DataInReady;
  logic              SOut;
  logic              TxBusy;
  logic [CountW-1:0] Count;

  modport master (output DataIn, DataInValid, input DataInReady, SOut, TxBusy, Count);
  modport slave  (input DataIn, DataInValid, output DataInReady, SOut, TxBusy, Count);
endinterface

// File: rtl/uart_buffered_tx.sv
// FIFO-buffered 8N1 UART transmitter, LSB first, contiguous back-to-back frames.
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop (8E1).
module uart_buffered_tx #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic              Clock,
  input logic              Reset,
  uart_buffered_tx_if.slave bus
);
  localparam int unsigned BitCycles = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned TimerW    = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;

  txState_t          state, stateNext;
  logic [TimerW-1:0] bitTimer, bitTimerNext;
  logic [2:0]        bitIdx, bitIdxNext;
  logic [7:0]        shiftReg, shiftNext;
  logic [PtrW-1:0]   rdPtr, wrPtr;
  logic [CountW-1:0] count, countNext;
  logic              sOutReg, sOutNext;
  logic              txBusyReg, txBusyNext;
  logic              readyReg, readyNext;
  logic              push, pop, bitEnd;
  logic [7:0]        fifoMem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic              parityBit, parityNext;
`endif

  assign bus.SOut        = sOutReg;
  assign bus.TxBusy      = txBusyReg;
  assign bus.DataInReady = readyReg;
  assign bus.Count       = count;

  // Ready is a register, so a write stalls while full even during a pop.
  assign push   = bus.DataInValid && readyReg;
  assign bitEnd = (bitTimer == TimerW'(BitCycles - 1));

  always_ff @(posedge Clock) begin
    if (push) fifoMem[wrPtr] <= bus.DataIn;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      bitTimer  <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      sOutReg   <= 1'b1;
      txBusyReg <= 1'b0;
      readyReg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      bitTimer  <= bitTimerNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      count     <= countNext;
      sOutReg   <= sOutNext;
      txBusyReg <= txBusyNext;
      readyReg  <= readyNext;
`ifdef UART_TX_PARITY_EN
      parityBit <= parityNext;
`endif
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
    end
  end

  // Next-state and next-output decode; SOut is computed for the state being entered.
  always_comb begin
    stateNext    = state;
    bitTimerNext = bitTimer;
    bitIdxNext   = bitIdx;
    shiftNext    = shiftReg;
    pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
    parityNext   = parityBit;
`endif
    case (state)
      IDLE: begin
        bitTimerNext = '0;
        if (count != '0) begin
          pop        = 1'b1;
          stateNext  = START;
          bitIdxNext = '0;
          shiftNext  = fifoMem[rdPtr];
`ifdef UART_TX_PARITY_EN
          parityNext = ^fifoMem[rdPtr];
`endif
        end
      end
      START: begin
        bitTimerNext = bitTimer + TimerW'(1);
        if (bitEnd) begin
          bitTimerNext = '0;
          stateNext    = DATA;
        end
      end
      DATA: begin
        bitTimerNext = bitTimer + TimerW'(1);
        if (bitEnd) begin
          bitTimerNext = '0;
          shiftNext    = shiftReg >> 1;
          bitIdxNext   = bitIdx + 3'd1;
          if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        bitTimerNext = bitTimer + TimerW'(1);
        if (bitEnd) begin
          bitTimerNext = '0;
          stateNext    = STOP;
        end
      end
`endif
      STOP: begin
        bitTimerNext = bitTimer + TimerW'(1);
        if (bitEnd) begin
          bitTimerNext = '0;
          if (count != '0) begin
            pop        = 1'b1;
            stateNext  = START;
            bitIdxNext = '0;
            shiftNext  = fifoMem[rdPtr];
`ifdef UART_TX_PARITY_EN
            parityNext = ^fifoMem[rdPtr];
`endif
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext    = IDLE;
        bitTimerNext = '0;
      end
    endcase

    countNext = count + CountW'(push) - CountW'(pop);

    case (stateNext)
      START:   sOutNext = 1'b0;
      DATA:    sOutNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  sOutNext = parityNext;
`endif
      default: sOutNext = 1'b1;
    endcase

    txBusyNext = (stateNext != IDLE) || (countNext != '0);
    readyNext  = (countNext != CountW'(FIFO_DEPTH));
  end
endmodule

// File: tb/tb_uart_buffered_tx.sv
// Self-checking bench for uart_buffered_tx against a frame-schedule reference model.
module tb_uart_buffered_tx;
  localparam int unsigned CF    = 1000;
  localparam int unsigned BR    = 100;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BC    = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned SEGS  = 11;
`else
  localparam int unsigned SEGS  = 10;
`endif
  localparam int unsigned FRAME = SEGS * BC;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  uart_buffered_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_buffered_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int unsigned cyc         = 0;

  // Model: every accepted byte gets a frame start time; frames are serial and in order.
  int unsigned startQ[$];
  logic [7:0]  byteQ[$];
  int unsigned lastEnd = 0;

  function automatic logic frameBit(input logic [7:0] b, input int unsigned seg);
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
`ifdef UART_TX_PARITY_EN
    if (seg == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic int unsigned expCount();
    int unsigned n = 0;
    foreach (startQ[i]) if (startQ[i] > cyc) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic        eSOut;
    int unsigned eCnt;
    while (startQ.size() > 0 && startQ[0] + FRAME <= cyc) begin
      void'(startQ.pop_front());
      void'(byteQ.pop_front());
    end
    eSOut = 1'b1;
    if (startQ.size() > 0 && startQ[0] <= cyc)
      eSOut = frameBit(byteQ[0], (cyc - startQ[0]) / BC);
    eCnt = expCount();
    check("SOut",        32'(bus.SOut),        32'(eSOut));
    check("Count",       32'(bus.Count),       eCnt);
    check("TxBusy",      32'(bus.TxBusy),      32'(startQ.size() > 0));
    check("DataInReady", 32'(bus.DataInReady), 32'(eCnt != DEPTH));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    logic        accept;
    int unsigned s;
    bus.DataInValid = v;
    bus.DataIn      = d;
    accept = v && (expCount() != DEPTH) && !Reset;
    @(posedge Clock);
    cyc++;
    if (accept) begin
      s = (cyc + 1 > lastEnd) ? cyc + 1 : lastEnd;
      startQ.push_back(s);
      byteQ.push_back(d);
      lastEnd = s + FRAME;
    end
    #1;
    checkAll();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic applyReset();
    Reset = 1'b1;
    #1;
    startQ.delete();
    byteQ.delete();
    lastEnd = 0;
    check("rst_SOut",   32'(bus.SOut),        32'd1);
    check("rst_Count",  32'(bus.Count),       32'd0);
    check("rst_TxBusy", 32'(bus.TxBusy),      32'd0);
    check("rst_Ready",  32'(bus.DataInReady), 32'd1);
    idle(2);
    Reset = 1'b0;
  endtask

  initial begin
    int unsigned s0;
    bus.DataInValid = 1'b0;
    bus.DataIn      = 8'h00;
    #2;
    applyReset();
    idle(20);

    // Single 0x55 frame, exact waveform and latency.
    step(1'b1, 8'h55);
    idle(FRAME + 10);

    // Two back-to-back bytes: contiguous frames.
    step(1'b1, 8'hA3);
    step(1'b1, 8'h0F);
    idle(2 * FRAME + 10);

    // Hold valid for 12 cycles: 9 accepted, then stalled while full.
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom));
    check("full_Count", 32'(bus.Count),       32'(DEPTH));
    check("full_Ready", 32'(bus.DataInReady), 32'd0);
    idle(9 * FRAME + 20);

    // Reset during the 4th data bit with 3 bytes queued.
    step(1'b1, 8'($urandom));
    s0 = startQ[0];
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
    while (cyc < s0 + 4 * BC + 3) step(1'b0, 8'h00);
    check("pre_rst_Count", 32'(bus.Count), 32'd3);
    applyReset();
    step(1'b1, 8'h7E);
    idle(FRAME + 10);

    // Parity-visible byte.
    step(1'b1, 8'h07);
    idle(FRAME + 10);

    // Quiet line.
    idle(500);

    // Random traffic with bursty writes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) step(1'b1, 8'($urandom));
      else step(1'b0, 8'($urandom));
    end
    idle(DEPTH * FRAME + 2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/uart_buffered_tx.md
# uart_buffered_tx

Buffered serial transmitter for the CPU's memory-mapped UART path: accepts bytes from the memory map over a valid/ready handshake, queues them in a small FIFO and serializes them 8N1, LSB first, on the serial output pin. It is the transmit end of the same byte handshake that the memory map drives. It lets the CPU issue short bursts of UART writes without polling between bytes.

## Interface

- CLOCK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, serial bit rate
- FIFO_DEPTH, 8, bytes of buffering; power of two, ≥2
- Clock  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- DataIn  input  8  byte to transmit
- DataInValid  input  1  DataIn holds a byte to enqueue
- DataInReady  output  1  FIFO can accept a byte this cycle
- SOut  output  1  serial line, idle high
- TxBusy  output  1  frame in progress or FIFO non-empty
- Count  output  $clog2(FIFO_DEPTH+1)  bytes currently in FIFO, excluding the byte being shifted

## Operation

- BIT_CYCLES = CLOCK_FREQ / BAUD_RATE, integer division (truncated); every serial bit lasts exactly BIT_CYCLES clocks.
- Enqueue: byte written at a rising edge where DataInValid && DataInReady. DataInReady = (Count != FIFO_DEPTH), decoded from registered state only; no combinational path from DataInValid.
- While full, DataInReady stays low even if a pop happens in the same cycle; the write is stalled, not dropped.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE: SOut=1. If Count != 0, pop head into shift register, clear bit counter, go to START.
  - START: SOut=0 for BIT_CYCLES, then DATA.
  - DATA: SOut = shift[0]; shift right every BIT_CYCLES; after 8 bits go to STOP.
  - STOP: SOut=1 for BIT_CYCLES. On its last cycle, if Count != 0, pop and go directly to START (no idle gap); else go to IDLE.
- Simultaneous push and pop (FIFO not full): Count unchanged; both take effect.
- Push into an empty FIFO while IDLE: the byte is popped the next edge; Count reads 1 for exactly one cycle.
- Read/write pointers wrap modulo FIFO_DEPTH.
- TxBusy = (state != IDLE) || (Count != 0).

## Timing

- Reset values: SOut=1, TxBusy=0, Count=0, DataInReady=1, FSM=IDLE, pointers=0.
- Reset asserted mid-frame: SOut forced to 1 immediately (asynchronously); FIFO contents discarded; the partial frame is not resumed.
- Latency: byte accepted at edge N into an empty, idle block → SOut falls at edge N+1.
- Frame length: 10·BIT_CYCLES clocks (11·BIT_CYCLES with parity). Back-to-back frames are contiguous.
- SOut is a register output; it is glitch-free.

## Configuration

- UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for BIT_CYCLES. The frame becomes 8E1.
- UART_TX_PARITY_EN undefined: no PARITY state; the frame is 8N1. The interface is identical in both builds.

## Test plan

- CLOCK_FREQ=1000, BAUD_RATE=100 (BIT_CYCLES=10); push 0x55 once. Expected SOut from the next edge: 0 ×10; data bits 1,0,1,0,1,0,1,0, each ×10; 1 ×10. Then TxBusy falls and SOut stays 1.
- Push 0xA3 then 0x0F on consecutive cycles. Expected: two contiguous 100-cycle frames with no idle cycle between them, and Count sequence 1,1,0 across the pops.
- Hold DataInValid high for 12 cycles from idle with FIFO_DEPTH=8. Expected: 9 bytes accepted (the first is popped immediately); DataInReady low from then on. DataInReady rises one cycle after the next pop. All bytes arrive on SOut in order.
- Assert Reset at the 4th data bit of a frame with 3 bytes queued. Expected: SOut=1 within the same cycle, Count=0, TxBusy=0. After release, a new push of 0x7E transmits cleanly.
- With UART_TX_PARITY_EN defined, push 0x07. Expected: parity bit = 1 after the data bits, then the stop bit; frame length 110 cycles.
- With DataInValid low and the FIFO empty for 500 cycles: SOut=1, TxBusy=0 and Count=0 throughout.
